// File: rtl/sub_top_pixel_fetch_if.sv
// Bus bundles for the pixel fetcher: Avalon-style read port toward the frame
// memory and the valid/ready pixel stream toward the display path.

interface sub_top_pixel_fetch_mem_if;
    logic [19:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata
    );
endinterface

interface sub_top_pixel_fetch_pix_if;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sop;
    logic        pix_eop;

    modport master (
        output pix_data, pix_valid, pix_sop, pix_eop,
        input  pix_ready
    );

    modport slave (
        input  pix_data, pix_valid, pix_sop, pix_eop,
        output pix_ready
    );
endinterface

// File: rtl/sub_top_pixel_fetch.sv
// Frame-memory read master: walks base..base+len-1, buffers words in a FIFO and
// streams them out with sop/eop tags. Define PIXEL_FETCH_LOOP_EN for continuous refresh.

module sub_top_pixel_fetch #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [19:0]               base_addr,
    input  logic [20:0]               frame_len,
    output logic                      busy,
    output logic                      done,
    sub_top_pixel_fetch_mem_if.master mem,
    sub_top_pixel_fetch_pix_if.master pix
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    logic [19:0]   cur_q;
    logic [20:0]   rem_q;
    logic [19:0]   base_q;
    logic [20:0]   len_q;
    logic [19:0]   addr_q;
    logic          cs_q;
    logic          tag_sop_q;
    logic          tag_eop_q;
    logic          pend_q;
    logic          pend_sop_q;
    logic          pend_eop_q;
    logic          busy_q;
    logic          done_q;

    logic [33:0]   fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [19:0]   src_cur_s;
    logic [20:0]   src_rem_s;
    logic [19:0]   src_base_s;
    logic [20:0]   src_len_s;
    logic          issue_s;
    logic          last_s;
    logic          credit_s;
    logic [CW:0]   credit_sum_s;
    logic          push_s;
    logic          pop_s;
    logic          eop_pop_s;
    logic [33:0]   head_s;
    logic          valid_s;

    assign head_s    = fifo_mem_q[rd_ptr_q];
    assign valid_s   = (count_q != {CW{1'b0}});
    assign pop_s     = valid_s && pix.pix_ready;
    assign push_s    = pend_q;
    assign eop_pop_s = pop_s && head_s[33];

    // Read-issue decision; buffered + in-flight words may never exceed the FIFO depth.
    always_comb begin
        src_cur_s    = cur_q;
        src_rem_s    = rem_q;
        src_base_s   = base_q;
        src_len_s    = len_q;
        issue_s      = 1'b0;
        credit_sum_s = {1'b0, count_q} + {{CW{1'b0}}, pend_q} + {{CW{1'b0}}, cs_q};
        credit_s     = (credit_sum_s < DEPTH_W);
        if (state_q == IDLE) begin
            src_cur_s  = base_addr;
            src_rem_s  = frame_len;
            src_base_s = base_addr;
            src_len_s  = frame_len;
            issue_s    = start && (frame_len != 21'd0);
        end else if (state_q == FETCH) begin
            issue_s = (rem_q != 21'd0) && credit_s;
        end else begin
            issue_s = 1'b0;
        end
        last_s = (src_rem_s == 21'd1);
    end

    // Control FSM, address walker and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_q      <= 20'd0;
            rem_q      <= 21'd0;
            base_q     <= 20'd0;
            len_q      <= 21'd0;
            addr_q     <= 20'd0;
            cs_q       <= 1'b0;
            tag_sop_q  <= 1'b0;
            tag_eop_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_sop_q <= 1'b0;
            pend_eop_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (stop) begin
            state_q <= IDLE;
            cs_q    <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cs_q       <= issue_s;
            pend_q     <= cs_q;
            pend_sop_q <= tag_sop_q;
            pend_eop_q <= tag_eop_q;
            done_q     <= eop_pop_s || ((state_q == IDLE) && start && (frame_len == 21'd0));
            if (issue_s) begin
                addr_q    <= src_cur_s;
                tag_sop_q <= (src_rem_s == src_len_s);
                tag_eop_q <= last_s;
                base_q    <= src_base_s;
                len_q     <= src_len_s;
                if (last_s) begin
`ifdef PIXEL_FETCH_LOOP_EN
                    cur_q   <= src_base_s;
                    rem_q   <= src_len_s;
                    state_q <= FETCH;
`else
                    cur_q   <= src_cur_s + 20'd1;
                    rem_q   <= 21'd0;
                    state_q <= DRAIN;
`endif
                end else begin
                    cur_q   <= src_cur_s + 20'd1;
                    rem_q   <= src_rem_s - 21'd1;
                    state_q <= FETCH;
                end
            end
            case (state_q)
                IDLE: begin
                    if (issue_s) begin
                        busy_q <= 1'b1;
                    end
                end
                FETCH: begin
                    busy_q <= 1'b1;
                end
                DRAIN: begin
                    if (eop_pop_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; stop and reset both discard buffered words.
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_q <= count_q + CNT_ONE;
            end else if (!push_s && pop_s) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // FIFO storage: {eop, sop, data} per entry.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= {pend_eop_q, pend_sop_q, mem.mem_readdata};
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign mem.mem_address    = addr_q;
    assign mem.mem_chipselect = cs_q;
    assign mem.mem_write      = 1'b0;
    assign mem.mem_byteenable = 4'hF;
    assign mem.mem_clken      = 1'b1;
    assign pix.pix_valid      = valid_s;
    assign pix.pix_data       = head_s[31:0];
    assign pix.pix_sop        = valid_s && head_s[32];
    assign pix.pix_eop        = valid_s && head_s[33];

endmodule
